// File: rtl/dsp_div_if.sv
// dsp_div request/response bundle.
// Master issues divisions, slave (the divider) returns results.
interface dsp_div_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_command;
   logic [31:0] req_in_1;
   logic [31:0] req_in_2;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_result;

   modport master (
      output req_valid, req_command, req_in_1, req_in_2, resp_ready,
      input  req_ready, resp_valid, resp_result
   );

   modport slave (
      input  req_valid, req_command, req_in_1, req_in_2, resp_ready,
      output req_ready, resp_valid, resp_result
   );
endinterface

// File: rtl/dsp_div.sv
// Sequential radix-2 restoring divider: scalar 32/32 or dual 16/16, signed/unsigned.
// Define DSP_DIV_EARLY_EXIT_EN to skip iterations when every lane is a special case.
module dsp_div (
   input  logic     clk,
   input  logic     reset,
   dsp_div_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic        pk_q, pk_d;
   logic        bad_q, bad_d;
   logic [31:0] in1_q, in1_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] r_q, r_d;
   logic [15:0] rh_q, rh_d;
   logic [1:0]  qsg_q, qsg_d;
   logic [1:0]  rsg_q, rsg_d;
   logic [1:0]  dz_q, dz_d;
   logic [1:0]  ov_q, ov_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        rv_q, rv_d;
   logic [63:0] res_q, res_d;

   function automatic logic [63:0] lane32(
      input logic [31:0] qm, rm, dvd,
      input logic qs, rs, dz, ov);
      logic [31:0] q, r;
      q = qs ? -qm : qm;
      r = rs ? -rm : rm;
      if (dz) begin
         q = '1;
         r = dvd;
      end else if (ov) begin
         q = dvd;
         r = '0;
      end
      return {r, q};
   endfunction

   function automatic logic [31:0] lane16(
      input logic [15:0] qm, rm, dvd,
      input logic qs, rs, dz, ov);
      logic [15:0] q, r;
      q = qs ? -qm : qm;
      r = rs ? -rm : rm;
      if (dz) begin
         q = '1;
         r = dvd;
      end else if (ov) begin
         q = dvd;
         r = '0;
      end
      return {r, q};
   endfunction

   // Scalar mode keeps its signs in index 1 and its special flags in index 0.
   function automatic logic [63:0] pack(
      input logic bad, pk,
      input logic [31:0] dvd, qm, rm,
      input logic [15:0] rmh,
      input logic [1:0] qs, rs, dz, ov);
      logic [31:0] lo, hi;
      if (bad) return '0;
      if (!pk) return lane32(qm, rm, dvd, qs[1], rs[1], dz[0], ov[0]);
      lo = lane16(qm[15:0], rm[15:0], dvd[15:0], qs[0], rs[0], dz[0], ov[0]);
      hi = lane16(qm[31:16], rmh, dvd[31:16], qs[1], rs[1], dz[1], ov[1]);
      return {hi[31:16], lo[31:16], hi[15:0], lo[15:0]};
   endfunction

   logic        ok, pk, sg, sp_all;
   logic [31:0] x, y, ax, ay;
   logic [1:0]  n1, n2, dz_p, ov_p, dz_in, ov_in;
   logic        dz_s, ov_s;

   assign x  = bus.req_in_1;
   assign y  = bus.req_in_2;
   assign ok = (bus.req_command[31:2] == '0);
   assign pk = ok & bus.req_command[1];
   assign sg = ok & bus.req_command[0];
   assign n1 = {sg & x[31], sg & x[15]};
   assign n2 = {sg & y[31], sg & y[15]};

   assign ax = pk ? {n1[1] ? -x[31:16] : x[31:16],
                     n1[0] ? -x[15:0]  : x[15:0]}
                  : (n1[1] ? -x : x);
   assign ay = pk ? {n2[1] ? -y[31:16] : y[31:16],
                     n2[0] ? -y[15:0]  : y[15:0]}
                  : (n2[1] ? -y : y);

   assign dz_s = (y == '0);
   assign ov_s = sg & (x == 32'h8000_0000) & (y == '1);
   assign dz_p = {y[31:16] == '0, y[15:0] == '0};
   assign ov_p = {sg & (x[31:16] == 16'h8000) & (y[31:16] == 16'hFFFF),
                  sg & (x[15:0] == 16'h8000) & (y[15:0] == 16'hFFFF)};
   assign dz_in = pk ? dz_p : {1'b0, dz_s};
   assign ov_in = pk ? ov_p : {1'b0, ov_s};

`ifdef DSP_DIV_EARLY_EXIT_EN
   assign sp_all = ok & (pk ? &(dz_p | ov_p) : (dz_s | ov_s));
`else
   assign sp_all = 1'b0;
`endif

   // One restoring step: both lane datapaths, selected by mode.
   logic [32:0] rs_s, ts;
   logic [16:0] rlo, tlo, rhi, thi;
   logic [31:0] a_nx, r_nx;
   logic [15:0] rh_nx;

   assign rs_s = {r_q, a_q[31]};
   assign ts   = rs_s - {1'b0, b_q};
   assign rlo  = {r_q[15:0], a_q[15]};
   assign tlo  = rlo - {1'b0, b_q[15:0]};
   assign rhi  = {rh_q, a_q[31]};
   assign thi  = rhi - {1'b0, b_q[31:16]};

   always_comb begin
      a_nx  = {a_q[30:0], ~ts[32]};
      r_nx  = ts[32] ? rs_s[31:0] : ts[31:0];
      rh_nx = '0;
      if (pk_q) begin
         a_nx  = {a_q[30:16], ~thi[16], a_q[14:0], ~tlo[16]};
         r_nx  = {16'h0, tlo[16] ? rlo[15:0] : tlo[15:0]};
         rh_nx = thi[16] ? rhi[15:0] : thi[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      pk_d    = pk_q;
      bad_d   = bad_q;
      in1_d   = in1_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      rh_d    = rh_q;
      qsg_d   = qsg_q;
      rsg_d   = rsg_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      cnt_d   = cnt_q;
      rv_d    = rv_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: if (bus.req_valid) begin
            pk_d    = pk;
            bad_d   = !ok;
            in1_d   = x;
            a_d     = ax;
            b_d     = ay;
            r_d     = '0;
            rh_d    = '0;
            qsg_d   = pk ? (n1 ^ n2) : {n1[1] ^ n2[1], 1'b0};
            rsg_d   = pk ? n1 : {n1[1], 1'b0};
            dz_d    = dz_in;
            ov_d    = ov_in;
            cnt_d   = pk ? 6'd16 : 6'd32;
            state_d = CALC;
            if (sp_all) begin
               state_d = DONE;
               rv_d    = 1'b1;
               res_d   = pack(1'b0, pk, x, '0, '0, '0,
                              qsg_d, rsg_d, dz_in, ov_in);
            end
         end
         CALC: begin
            a_d   = a_nx;
            r_d   = r_nx;
            rh_d  = rh_nx;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = DONE;
               rv_d    = 1'b1;
               res_d   = pack(bad_q, pk_q, in1_q, a_nx, r_nx, rh_nx,
                              qsg_q, rsg_q, dz_q, ov_q);
            end
         end
         DONE: if (bus.resp_ready) begin
            state_d = IDLE;
            rv_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pk_q    <= 1'b0;
         bad_q   <= 1'b0;
         in1_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         rh_q    <= '0;
         qsg_q   <= '0;
         rsg_q   <= '0;
         dz_q    <= '0;
         ov_q    <= '0;
         cnt_q   <= '0;
         rv_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         pk_q    <= pk_d;
         bad_q   <= bad_d;
         in1_q   <= in1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         rh_q    <= rh_d;
         qsg_q   <= qsg_d;
         rsg_q   <= rsg_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
         res_q   <= res_d;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.resp_valid  = rv_q;
   assign bus.resp_result = res_q;
endmodule

// File: tb/tb_dsp_div.sv
// Self-checking bench for dsp_div: directed table, corner sequences and
// random operations against an arithmetic reference model.
module tb_dsp_div;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   dsp_div_if bus ();

   dsp_div dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mdl32(input logic [31:0] x, y,
                                         input bit sg);
      longint sx, sy, q, r;
      if (y == 0) return {x, 32'hFFFF_FFFF};
      sx = sg ? longint'($signed(x)) : longint'(x);
      sy = sg ? longint'($signed(y)) : longint'(y);
      if (sg && sx == -64'sd2147483648 && sy == -1) return {32'h0, x};
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] mdl16(input logic [15:0] x, y,
                                         input bit sg);
      longint sx, sy, q, r;
      if (y == 0) return {x, 16'hFFFF};
      sx = sg ? longint'($signed(x)) : longint'(x);
      sy = sg ? longint'($signed(y)) : longint'(y);
      if (sg && sx == -32768 && sy == -1) return {16'h0, x};
      q = sx / sy;
      r = sx % sy;
      return {r[15:0], q[15:0]};
   endfunction

   function automatic logic [63:0] model(input logic [31:0] cmd, x, y);
      logic [31:0] lo, hi;
      case (cmd)
         0: return mdl32(x, y, 1'b0);
         1: return mdl32(x, y, 1'b1);
         2, 3: begin
            lo = mdl16(x[15:0], y[15:0], cmd == 3);
            hi = mdl16(x[31:16], y[31:16], cmd == 3);
            return {hi[31:16], lo[31:16], hi[15:0], lo[15:0]};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Clock edges after the accept edge until resp_valid is seen.
   function automatic int exp_lat(input logic [31:0] cmd, x, y);
      bit pk, sg, sl, sh, ss;
      pk = (cmd == 2) || (cmd == 3);
      sg = (cmd == 1) || (cmd == 3);
      ss = (y == 0) || (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
      sl = (y[15:0] == 0) ||
           (sg && x[15:0] == 16'h8000 && y[15:0] == 16'hFFFF);
      sh = (y[31:16] == 0) ||
           (sg && x[31:16] == 16'h8000 && y[31:16] == 16'hFFFF);
`ifdef DSP_DIV_EARLY_EXIT_EN
      if (cmd <= 3 && (pk ? (sl && sh) : ss)) return 0;
`else
      if (sl && sh && ss && 0) return 0;
`endif
      return pk ? 16 : 32;
   endfunction

   // Called at #1 after a rising edge with the DUT in IDLE.
   task automatic do_op(input logic [31:0] cmd, x, y, input int hold,
                        input string tag);
      logic [63:0] exp;
      int k;
      exp = model(cmd, x, y);
      chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
      bus.resp_ready  = (hold == 0);
      bus.req_valid   = 1'b1;
      bus.req_command = cmd;
      bus.req_in_1    = x;
      bus.req_in_2    = y;
      @(posedge clk);
      #1;
      bus.req_valid   = 1'b0;
      bus.req_command = $urandom;
      bus.req_in_1    = $urandom;
      bus.req_in_2    = $urandom;
      k = 0;
      while (!bus.resp_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, " latency"}, 64'(k), 64'(exp_lat(cmd, x, y)));
      chk({tag, " result"}, bus.resp_result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, " hold valid"}, 64'(bus.resp_valid), 64'd1);
         chk({tag, " hold result"}, bus.resp_result, exp);
         chk({tag, " hold ready"}, 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " valid drop"}, 64'(bus.resp_valid), 64'd0);
      chk({tag, " ready back"}, 64'(bus.req_ready), 64'd1);
      chk({tag, " result kept"}, bus.resp_result, exp);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h8000_FFFF;
         4: return {$urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom),
                    $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom)};
         5: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic seen;
      logic [31:0] c;
      tbl[0]  = '{32'd0, 32'd100, 32'd7, 64'h00000002_0000000E};
      tbl[1]  = '{32'd1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD};
      tbl[2]  = '{32'd2, 32'h0064_0009, 32'h0007_0002,
                  64'h0002_0001_000E_0004};
      tbl[3]  = '{32'd0, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF};
      tbl[4]  = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF,
                  64'h00000000_80000000};
      tbl[5]  = '{32'd3, 32'hFFF9_0007, 32'h0002_FFFE,
                  64'hFFFF_0001_FFFD_FFFD};
      tbl[6]  = '{32'd3, 32'h8000_0005, 32'hFFFF_0000,
                  64'h0000_0005_8000_FFFF};
      tbl[7]  = '{32'd2, 32'h0010_0005, 32'h0000_0002,
                  64'h0010_0001_FFFF_0002};
      tbl[8]  = '{32'd5, 32'd100, 32'd7, 64'h0};
      tbl[9]  = '{32'd0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF};
      tbl[10] = '{32'd1, 32'h8000_0000, 32'd1, 64'h00000000_80000000};
      tbl[11] = '{32'd1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};

      bus.req_valid   = 1'b0;
      bus.req_command = '0;
      bus.req_in_1    = '0;
      bus.req_in_2    = '0;
      bus.resp_ready  = 1'b1;
      #12;
      chk("reset req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("reset resp_result", bus.resp_result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         do_op(tbl[i].cmd, tbl[i].in1, tbl[i].in2, 0, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d expect", i), bus.resp_result, tbl[i].exp);
      end

      do_op(32'd0, 32'd1000, 32'd3, 10, "backpressure");
      do_op(32'd3, 32'h8000_0000, 32'hFFFF_0000, 3, "bp special");

      bus.req_valid   = 1'b1;
      bus.req_command = 32'd0;
      bus.req_in_1    = 32'd1000;
      bus.req_in_2    = 32'd3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("abort resp_result", bus.resp_result, 64'd0);
      chk("abort req_ready", 64'(bus.req_ready), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid) seen = 1'b1;
      end
      chk("abort no response", 64'(seen), 64'd0);
      do_op(32'd1, 32'hFFFF_FC18, 32'd7, 0, "after reset");

      for (int i = 0; i < 150; i++) begin
         c = 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) c = $urandom | 32'h4;
         do_op(c, pick(), pick(), 0, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
